// File: rtl/mem_arbiter_rr_if.sv
// Client-side and physical-memory-side bundle for mem_arbiter_rr.
// The arbiter takes the slave view. The caches and pmem (or a bench) take the master view.
interface mem_arbiter_rr_if #(
   parameter int NUM_PORTS = 2,
   parameter int LINE_W    = 128,
   parameter int ADDR_W    = 16
);
   logic [NUM_PORTS-1:0]        req_read;
   logic [NUM_PORTS-1:0]        req_write;
   logic [NUM_PORTS*ADDR_W-1:0] req_address;
   logic [NUM_PORTS*LINE_W-1:0] req_wdata;
   logic [NUM_PORTS-1:0]        req_resp;
   logic [LINE_W-1:0]           req_rdata;
   logic                        pmem_resp;
   logic [LINE_W-1:0]           pmem_rdata;
   logic                        pmem_read;
   logic                        pmem_write;
   logic [ADDR_W-1:0]           pmem_address;
   logic [LINE_W-1:0]           pmem_wdata;

   modport slave (
      input  req_read, req_write, req_address, req_wdata, pmem_resp, pmem_rdata,
      output req_resp, req_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport master (
      output req_read, req_write, req_address, req_wdata, pmem_resp, pmem_rdata,
      input  req_resp, req_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-port cache-line arbiter onto a single physical-memory port, round-robin by default.
// Define MEM_ARB_FIXED_PRI_EN for fixed priority, where the lowest pending port index wins.
module mem_arbiter_rr #(
   parameter int NUM_PORTS = 2,
   parameter int LINE_W    = 128,
   parameter int ADDR_W    = 16
) (
   input logic              clk,
   input logic              reset_n,
   mem_arbiter_rr_if.slave  bus
);
   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [PTR_W-1:0]     grant_q, grant_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [LINE_W-1:0]    wdata_q, wdata_d;
   logic [LINE_W-1:0]    rdata_q, rdata_d;
   logic                 rd_q, rd_d;
   logic                 wr_q, wr_d;
   logic [NUM_PORTS-1:0] resp_q, resp_d;

   logic [NUM_PORTS-1:0] pending;
   logic                 any_pending;
   logic [PTR_W-1:0]     winner;
   logic [ADDR_W-1:0]    win_addr;
   logic [LINE_W-1:0]    win_wdata;
   logic                 win_write;

   assign pending     = bus.req_read | bus.req_write;
   assign any_pending = |pending;

`ifdef MEM_ARB_FIXED_PRI_EN
   // Scanning downward leaves the lowest pending index in winner.
   always_comb begin
      winner = '0;
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
         if (pending[p]) winner = PTR_W'(p);
      end
   end
`else
   function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] last, input int step);
      return PTR_W'((int'(last) + step) % NUM_PORTS);
   endfunction

   // grant_q doubles as last_grant. Scanning from the far end leaves the nearest pending port after it.
   always_comb begin
      winner = '0;
      for (int i = NUM_PORTS; i >= 1; i--) begin
         if (pending[rr_idx(grant_q, i)]) winner = rr_idx(grant_q, i);
      end
   end
`endif

   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_write = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (PTR_W'(p) == winner) begin
            win_addr  = bus.req_address[p*ADDR_W +: ADDR_W];
            win_wdata = bus.req_wdata[p*LINE_W +: LINE_W];
            win_write = bus.req_write[p];
         end
      end
   end

   // NOTE: every always_comb output gets a default first; a path that skips an assignment infers a latch.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      resp_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (any_pending) begin
               grant_d = winner;
               addr_d  = win_addr;
               wdata_d = win_wdata;
               wr_d    = win_write;
               rd_d    = ~win_write;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (bus.pmem_resp) begin
               // Writes leave the previously returned line visible on req_rdata.
               if (rd_q) rdata_d = bus.pmem_rdata;
               rd_d            = 1'b0;
               wr_d            = 1'b0;
               resp_d[grant_q] = 1'b1;
               state_d         = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         grant_q <= PTR_W'(NUM_PORTS - 1);
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         resp_q  <= resp_d;
      end
   end

   assign bus.pmem_read    = rd_q;
   assign bus.pmem_write   = wr_q;
   assign bus.pmem_address = addr_q;
   assign bus.pmem_wdata   = wdata_q;
   assign bus.req_resp     = resp_q;
   assign bus.req_rdata    = rdata_q;
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr with 4 ports: vector table, reset abort and fairness sequences.
// The expected grant order follows MEM_ARB_FIXED_PRI_EN when it is defined.
module tb_mem_arbiter_rr;
   localparam int NP = 4;
   localparam int LW = 128;
   localparam int AW = 16;

   typedef struct {
      int            port;
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      int            lat;
      logic [LW-1:0] rdata;
   } vec_t;

   typedef struct {
      logic [NP-1:0] resp;
      logic [LW-1:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic [LW-1:0] last_rdata = '0;
   vec_t vecs[5];

   mem_arbiter_rr_if #(.NUM_PORTS(NP), .LINE_W(LW), .ADDR_W(AW)) bus ();

   mem_arbiter_rr #(.NUM_PORTS(NP), .LINE_W(LW), .ADDR_W(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive_req(input int port, input logic rd, input logic wr,
                            input logic [AW-1:0] addr, input logic [LW-1:0] wd);
      bus.req_read[port]            = rd;
      bus.req_write[port]           = wr;
      bus.req_address[port*AW +: AW] = addr;
      bus.req_wdata[port*LW +: LW]   = wd;
   endtask

   task automatic wait_strobe();
      int n = 0;
      while (!(bus.pmem_read | bus.pmem_write) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("grant_seen", LW'(bus.pmem_read | bus.pmem_write), LW'(1));
   endtask

   task automatic check_grant(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] wd);
      check("grant_strobes", LW'({bus.pmem_read, bus.pmem_write}), wr ? LW'(1) : LW'(2));
      check("grant_addr", LW'(bus.pmem_address), LW'(addr));
      if (wr) check("grant_wdata", bus.pmem_wdata, wd);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_underflow actual=%h expected=pending_entry", bus.req_resp);
      end else begin
         e = sb.pop_front();
         check("req_resp", LW'(bus.req_resp), LW'(e.resp));
         check("req_rdata", bus.req_rdata, e.rdata);
      end
   endtask

   // Entered at a negedge with the strobe already high; returns at the negedge where req_resp is high.
   task automatic finish_txn(input int lat, input logic [LW-1:0] drv, input logic [AW-1:0] addr, input logic wr);
      for (int k = 1; k < lat; k++) begin
         @(negedge clk);
         check("strobe_held", LW'({bus.pmem_read, bus.pmem_write}), wr ? LW'(1) : LW'(2));
         check("addr_held", LW'(bus.pmem_address), LW'(addr));
      end
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = drv;
      @(negedge clk);
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = {4{$urandom}};
      check("strobe_drop", LW'({bus.pmem_read, bus.pmem_write}), '0);
      pop_check();
   endtask

   initial begin
      vecs[0] = '{port: 1, rd: 1'b1, wr: 1'b0, addr: 16'h1240, wdata: '0, lat: 5, rdata: {16{8'hA5}}};
      vecs[1] = '{port: 0, rd: 1'b0, wr: 1'b1, addr: 16'h0080,
                  wdata: 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, lat: 3, rdata: '0};
      vecs[2] = '{port: 2, rd: 1'b1, wr: 1'b1, addr: 16'h2200, wdata: {4{32'hDEADBEEF}}, lat: 1, rdata: '0};
      vecs[3] = '{port: 3, rd: 1'b1, wr: 1'b0, addr: 16'hFFFF, wdata: '0, lat: 1, rdata: {LW{1'b1}}};
      vecs[4] = '{port: 0, rd: 1'b1, wr: 1'b0, addr: 16'h0000, wdata: '0, lat: 2, rdata: {8{16'hC3C3}}};

      bus.req_read = '0; bus.req_write = '0; bus.req_address = '0; bus.req_wdata = '0;
      bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;

      // Reset state and 20 idle cycles.
      repeat (3) @(negedge clk);
      check("rst_strobes", LW'({bus.pmem_read, bus.pmem_write}), '0);
      check("rst_resp", LW'(bus.req_resp), '0);
      reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("idle_strobes", LW'({bus.pmem_read, bus.pmem_write, bus.req_resp}), '0);
      end
      check("idle_addr", LW'(bus.pmem_address), '0);
      check("idle_wdata", bus.pmem_wdata, '0);
      check("idle_rdata", bus.req_rdata, '0);

      // Table-driven single transactions.
      for (int v = 0; v < 5; v++) begin
         exp_t e;
         logic [LW-1:0] drv;
         drv = vecs[v].wr ? last_rdata : vecs[v].rdata;
         e.resp  = NP'(1) << vecs[v].port;
         e.rdata = drv;
         drive_req(vecs[v].port, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
         sb.push_back(e);
         @(negedge clk);
         check("grant_latency", LW'(bus.pmem_read | bus.pmem_write), LW'(1));
         wait_strobe();
         check_grant(vecs[v].wr, vecs[v].addr, vecs[v].wdata);
         drive_req(vecs[v].port, vecs[v].rd, vecs[v].wr, ~vecs[v].addr, ~vecs[v].wdata);
         finish_txn(vecs[v].lat, drv, vecs[v].addr, vecs[v].wr);
         if (!vecs[v].wr) last_rdata = vecs[v].rdata;
         drive_req(vecs[v].port, 1'b0, 1'b0, '0, '0);
         @(negedge clk);
         check("resp_one_cycle", LW'(bus.req_resp), '0);
      end

      // Reset during BUSY, then a stale pmem_resp while port 0 is granted.
      begin
         exp_t e;
         drive_req(2, 1'b1, 1'b0, 16'h3330, '0);
         e.resp = 4'b0100; e.rdata = '0;
         sb.push_back(e);
         wait_strobe();
         check("abort_addr", LW'(bus.pmem_address), LW'(16'h3330));
         reset_n = 1'b0;
         #1;
         check("abort_strobes", LW'({bus.pmem_read, bus.pmem_write}), '0);
         check("abort_addr_clr", LW'(bus.pmem_address), '0);
         sb.delete();
         drive_req(2, 1'b0, 1'b0, '0, '0);
         @(negedge clk);
         reset_n = 1'b1;
         bus.pmem_resp  = 1'b1;
         bus.pmem_rdata = {8{16'hBAD0}};
         drive_req(3, 1'b1, 1'b0, 16'h3003, '0);
         drive_req(0, 1'b1, 1'b0, 16'h0A0A, '0);
         e.resp = 4'b0001; e.rdata = {4{32'h7777_0000}};
         sb.push_back(e);
         @(negedge clk);
         bus.pmem_resp = 1'b0;
         check("post_rst_addr", LW'(bus.pmem_address), LW'(16'h0A0A));
         check("stale_resp_ignored", LW'({bus.pmem_read, bus.req_resp}), LW'(5'b10000));
         finish_txn(2, {4{32'h7777_0000}}, 16'h0A0A, 1'b0);
         drive_req(0, 1'b0, 1'b0, '0, '0);
         @(negedge clk);
         check("resp_one_cycle", LW'(bus.req_resp), '0);
         e.resp = 4'b1000; e.rdata = {4{32'h0000_3333}};
         sb.push_back(e);
         wait_strobe();
         check_grant(1'b0, 16'h3003, '0);
         finish_txn(1, {4{32'h0000_3333}}, 16'h3003, 1'b0);
         drive_req(3, 1'b0, 1'b0, '0, '0);
         @(negedge clk);
      end

      // Fairness: all ports hold continuous reads.
      for (int p = 0; p < NP; p++) drive_req(p, 1'b1, 1'b0, AW'(16'h4000 + p), '0);
      for (int i = 0; i < 6; i++) begin
         exp_t e;
         int   ep;
`ifdef MEM_ARB_FIXED_PRI_EN
         ep = 0;
`else
         ep = i % NP;
`endif
         e.resp  = NP'(1) << ep;
         e.rdata = {8{16'(16'h5A00 + i)}};
         sb.push_back(e);
         wait_strobe();
         check("fair_addr", LW'(bus.pmem_address), LW'(16'h4000 + ep));
         finish_txn(1, e.rdata, AW'(16'h4000 + ep), 1'b0);
         @(negedge clk);
         check("resp_one_cycle", LW'(bus.req_resp), '0);
      end
      bus.req_read = '0;
      repeat (3) @(negedge clk);
      check("final_idle", LW'({bus.pmem_read, bus.pmem_write, bus.req_resp}), '0);
      check("sb_drained", LW'(sb.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised N-port physical-memory arbiter: multiplexes cache-line read/write requests from `NUM_PORTS` cache clients (I-cache, D-cache, L2 victim/prefetch paths) onto a single physical-memory port. It generalises the two-port, I/D-only arbiter with a configurable port count, line width and address width. It also adds round-robin fairness, write traffic from any port, and registered request/response paths. It sits between the per-client caches and `pmem` at the top level.

## Interface
- `NUM_PORTS`, 2: number of client ports (2..8); port index 0 = D-cache by convention.
- `LINE_W`, 128: cache-line data width in bits.
- `ADDR_W`, 16: physical address width in bits.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_read`  in  NUM_PORTS  per-port line-read request; held high until that port's `req_resp`.
- `req_write`  in  NUM_PORTS  per-port line-write request; held high until that port's `req_resp`.
- `req_address`  in  NUM_PORTS*ADDR_W  per-port address; port p at bits [p*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_PORTS*LINE_W  per-port write line; port p at bits [p*LINE_W +: LINE_W].
- `req_resp`  out  NUM_PORTS  one-hot, one-cycle completion pulse to the granted port.
- `req_rdata`  out  LINE_W  read line, shared by all ports; valid only with `req_resp`.
- `pmem_resp`  in  1  physical-memory completion.
- `pmem_rdata`  in  LINE_W  physical-memory read line; valid with `pmem_resp`.
- `pmem_read`  out  1  physical-memory read strobe.
- `pmem_write`  out  1  physical-memory write strobe.
- `pmem_address`  out  ADDR_W  physical-memory address.
- `pmem_wdata`  out  LINE_W  physical-memory write line.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state IDLE.
- IDLE:
  - A port is pending if `req_read[p] | req_write[p]`.
  - If any port is pending, select the winner (see arbitration) and latch its index, address and wdata.
  - Latch the op: write if `req_write[p]`, else read. Write wins if both are high.
  - Go to BUSY. If no port is pending, stay in IDLE.
- Arbitration: round-robin. Search starts at `last_grant+1` modulo NUM_PORTS and takes the first pending port. `last_grant` updates to the winner on each grant.
- BUSY:
  - Drive `pmem_read`/`pmem_write` (exactly one), `pmem_address` and `pmem_wdata` from the latched registers, held stable.
  - On `pmem_resp`, capture `pmem_rdata` into the rdata register, deassert both strobes and go to RESP.
- RESP:
  - `req_resp[grant]`=1 for exactly this cycle.
  - `req_rdata` = captured line; for writes it holds the last captured value.
  - Then go to IDLE.
- `pmem_resp` in IDLE or RESP is ignored.
- Request changes on the granted port while BUSY are ignored (latched copy used). Requests on other ports wait.
- Reset asserted mid-operation: transaction is abandoned and the FSM returns to IDLE.
- Output and register values under reset (all zero):
  - `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `req_resp`, `req_rdata` = 0.
  - `last_grant` = NUM_PORTS-1, so port 0 wins first.

## Timing
- Grant latency: a request present in IDLE at edge N makes the pmem strobe high from edge N onward (cycle after sampling).
- Response latency: `pmem_resp` sampled at edge M → `req_resp` high in cycle M..M+1 → IDLE at M+1.
- Back-to-back: the earliest next grant is sampled at edge M+2. Minimum occupancy is 3 cycles per transaction plus memory latency.
- Strobes and address are registered outputs with no combinational input-to-output paths. `req_resp`/`req_rdata` are registered.
- Starvation bound under round-robin: a pending port waits at most NUM_PORTS-1 transactions.

## Configuration
- `MEM_ARB_FIXED_PRI_EN`:
  - Defined: fixed priority; the lowest pending port index always wins and `last_grant` is unused.
  - Undefined (default): round-robin as above.

## Test plan
- Reset release, no requests, 20 cycles → all outputs 0, FSM in IDLE, no strobes.
- Single read: port 1 `req_read`, addr 0x1240; memory responds after 5 cycles with line 0xA5..A5 → `pmem_read`=1 at addr 0x1240 until resp, then `req_resp`=2'b10 for one cycle with `req_rdata`=0xA5..A5.
- Write: port 0 `req_write`, addr 0x0080, wdata 0x1234..; check strobes and `req_resp`:
  - `pmem_write`=1 with exact address and wdata; `pmem_read` never high.
  - `req_resp`=2'b01 one cycle.
- Fairness (NUM_PORTS=4): all ports hold continuous reads → grant order 0,1,2,3,0,1…. With `MEM_ARB_FIXED_PRI_EN` the order is 0,0,0….
- Read+write both high on port 2 → transaction is a write.
- `reset_n` low in BUSY before `pmem_resp` → strobes drop immediately; after release, a port-0 request is granted first and the stale `pmem_resp` is ignored.
